rriot_bus_master: RTL and testbench
===================================

// Module: rriot_bus_master
// PURPOSE
// - Command-driven bus initiator for the RRIOT timer's CPU-side register port.
// - Turns queued read/write commands into single-cycle enable strobes and captures read data.
// - Latches and counts timer interrupts for the host.
// - Sits between a host command source (sequencer/test harness) and the timer responder.
// PARAMETERS
// READ_TIMEOUT  4  cycles to wait for bus_oe after a read strobe; legal 1..15
// IRQ_COUNT_W   8  width of saturating irq event counter
// PORTS
// clk          in   1   system clock; all logic on posedge
// rst          in   1   synchronous reset, active-high
// cmd_valid    in   1   host command offered
// cmd_ready    out  1   master can accept command (high only in IDLE)
// cmd_write    in   1   1=write, 0=read
// cmd_addr     in   3   register address driven onto bus_addr
// cmd_wdata    in   8   write data driven onto bus_dout
// rsp_valid    out  1   response available; held until rsp_ready
// rsp_ready    in   1   host accepts response
// rsp_write    out  1   response belongs to a write
// rsp_data     out  8   read data; 0x00 for writes and timeouts
// rsp_err      out  1   read timed out (bus_oe never seen)
// bus_enable   out  1   chip-select strobe to timer
// bus_we_n     out  1   0=write, 1=read
// bus_addr     out  3   timer address
// bus_dout     out  8   data to timer (timer DI)
// bus_din      in   8   data from timer (timer DO)
// bus_oe       in   1   timer indicates bus_din valid
// bus_irq      in   1   timer irq, active-low
// irq_ack      in   1   one-cycle pulse: clear irq_pending and irq_count
// irq_pending  out  1   sticky: an irq event seen since last ack
// irq_count    out  IRQ_COUNT_W  irq falling edges since last ack, saturating
// BEHAVIOUR
// - All outputs registered. Reset values:
//   - bus_enable=0, bus_we_n=1, bus_addr=0, bus_dout=0
//   - cmd_ready=1, rsp_*=0, irq_pending=0, irq_count=0
//   - irq_prev=1; state=IDLE, timeout counter=0
// - FSM states: IDLE, STROBE, WAIT, RESP.
// - IDLE:
//   - cmd_ready=1.
//   - On cmd_valid at edge E0, register the command and go to STROBE.
//   - At E0: bus_enable<=1, bus_we_n<=~cmd_write, bus_addr<=cmd_addr, bus_dout<=cmd_wdata.
//   - cmd_ready<=0.
// - STROBE:
//   - Exactly one cycle with bus_enable=1.
//   - At next edge E1: bus_enable<=0, bus_we_n<=1; addr and dout hold their values.
//   - Write: go to RESP (rsp_write=1, data=0, err=0).
//   - Read: go to WAIT with counter=0.
// - WAIT:
//   - Each edge: if bus_oe=1, rsp_data<=bus_din, err=0, go to RESP.
//   - Otherwise counter++.
//   - When counter reaches READ_TIMEOUT-1 without bus_oe: rsp_data=0x00, rsp_err=1, go to RESP.
//   - Minimum read latency is cmd accept to rsp_valid = 3 edges.
//   - Timer returns bus_oe only for addresses with bit0=0; odd-address reads time out by design.
// - RESP:
//   - rsp_valid=1, with rsp_* stable, until rsp_ready is sampled high.
//   - Then rsp_valid<=0, cmd_ready<=1, go to IDLE.
//   - No command is accepted in the same edge as the response handshake.
// - Write data is passed unmodified; the timer applies its own -1 on load.
// - IRQ path (independent of FSM):
//   - irq_prev<=bus_irq every cycle.
//   - Event = irq_prev=1 and bus_irq=0.
//   - An event sets irq_pending and increments irq_count, saturating at all-ones.
//   - irq_ack clears both.
//   - Event and ack in the same cycle: pending=1, count=1 (event wins).
// - Reset mid-operation:
//   - Next edge forces the reset values; an in-flight strobe ends.
//   - Any pending response is discarded.
// TESTING
// - Write addr=3'b111 data=0x10 -> one cycle bus_enable=1, we_n=0, dout=0x10.
//   Then rsp_valid with rsp_write=1, err=0, data=0x00.
// - Read addr=3'b100, model drives oe=1 din=0x0E the cycle after strobe.
//   -> rsp_data=0x0E, err=0, rsp_valid 3 edges after accept.
// - Read addr=3'b001, oe never asserted -> rsp_err=1, data=0x00 after READ_TIMEOUT WAIT cycles.
// - Hold rsp_ready=0 for 5 cycles -> rsp_valid and data held stable, cmd_ready=0, no new bus strobe.
// - Three irq low pulses -> irq_count=3, pending=1.
//   Ack coincident with a 4th pulse -> count=1, pending=1.
//   300 pulses -> count=255.
// - Assert rst during WAIT -> next cycle bus_enable=0, cmd_ready=1, rsp_valid=0, irq_count=0.

Source files
------------

// File: rtl/rriot_bus_master_if.sv
// Host command/response, timer bus and irq signals for the RRIOT bus master.
// No timing of its own; all signals are plain wires between master and peers.
// Flow control is cmd_valid/cmd_ready and rsp_valid/rsp_ready.
interface rriot_bus_master_if #(
    parameter int IRQ_COUNT_W = 8
);
    // host command channel
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic [2:0]             cmd_addr;
    logic [7:0]             cmd_wdata;
    // host response channel
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_write;
    logic [7:0]             rsp_data;
    logic                   rsp_err;
    // timer register port
    logic                   bus_enable;
    logic                   bus_we_n;
    logic [2:0]             bus_addr;
    logic [7:0]             bus_dout;
    logic [7:0]             bus_din;
    logic                   bus_oe;
    // interrupt side
    logic                   bus_irq;
    logic                   irq_ack;
    logic                   irq_pending;
    logic [IRQ_COUNT_W-1:0] irq_count;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  bus_din, bus_oe, bus_irq, irq_ack,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_data, rsp_err,
        output bus_enable, bus_we_n, bus_addr, bus_dout,
        output irq_pending, irq_count
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output bus_din, bus_oe, bus_irq, irq_ack,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_data, rsp_err,
        input  bus_enable, bus_we_n, bus_addr, bus_dout,
        input  irq_pending, irq_count
    );
endinterface

// File: rtl/rriot_bus_master.sv
// Command-driven initiator for the RRIOT timer register port, plus irq latch/counter.
// Write response 2 edges after accept; read 2+N edges (N = cycle of bus_oe, max READ_TIMEOUT).
// One command in flight; cmd_ready low from accept until rsp_ready is sampled in RESP.
module rriot_bus_master #(
    parameter int READ_TIMEOUT = 4,
    parameter int IRQ_COUNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    rriot_bus_master_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] TMO_LAST = 4'(READ_TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic                   is_write_q, is_write_d;
    logic [3:0]             tmo_cnt_q, tmo_cnt_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_write_q, rsp_write_d;
    logic [7:0]             rsp_data_q, rsp_data_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   bus_enable_q, bus_enable_d;
    logic                   bus_we_n_q, bus_we_n_d;
    logic [2:0]             bus_addr_q, bus_addr_d;
    logic [7:0]             bus_dout_q, bus_dout_d;
    logic                   irq_prev_q, irq_prev_d;
    logic                   irq_pending_q, irq_pending_d;
    logic [IRQ_COUNT_W-1:0] irq_count_q, irq_count_d;
    logic                   irq_event;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: oe takes priority over the timeout on the last WAIT edge
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.cmd_valid) state_d = S_STROBE;
            S_STROBE: state_d = is_write_q ? S_RESP : S_WAIT;
            S_WAIT:   if (bus.bus_oe || (tmo_cnt_q == TMO_LAST)) state_d = S_RESP;
            S_RESP:   if (bus.rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; strobe and we_n fall back to idle levels every cycle
    always_comb begin
        is_write_d   = is_write_q;
        tmo_cnt_d    = tmo_cnt_q;
        rsp_write_d  = rsp_write_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        bus_enable_d = 1'b0;
        bus_we_n_d   = 1'b1;
        bus_addr_d   = bus_addr_q;
        bus_dout_d   = bus_dout_q;
        cmd_ready_d  = (state_d == S_IDLE);
        rsp_valid_d  = (state_d == S_RESP);
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    is_write_d   = bus.cmd_write;
                    bus_enable_d = 1'b1;
                    bus_we_n_d   = ~bus.cmd_write;
                    bus_addr_d   = bus.cmd_addr;
                    bus_dout_d   = bus.cmd_wdata;
                end
            end
            S_STROBE: begin
                tmo_cnt_d = 4'd0;
                if (is_write_q) begin
                    rsp_write_d = 1'b1;
                    rsp_data_d  = 8'h00;
                    rsp_err_d   = 1'b0;
                end
            end
            S_WAIT: begin
                if (bus.bus_oe) begin
                    rsp_write_d = 1'b0;
                    rsp_data_d  = bus.bus_din;
                    rsp_err_d   = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_write_d = 1'b0;
                    rsp_data_d  = 8'h00;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    // Irq edge detect: a falling edge beats a coincident ack and restarts the count at 1
    always_comb begin
        irq_prev_d    = bus.bus_irq;
        irq_event     = irq_prev_q & ~bus.bus_irq;
        irq_pending_d = irq_pending_q;
        irq_count_d   = irq_count_q;
        if (irq_event) begin
            irq_pending_d = 1'b1;
            if (bus.irq_ack)       irq_count_d = IRQ_COUNT_W'(1);
            else if (~&irq_count_q) irq_count_d = irq_count_q + IRQ_COUNT_W'(1);
        end else if (bus.irq_ack) begin
            irq_pending_d = 1'b0;
            irq_count_d   = '0;
        end
    end

    // Registered outputs and datapath; reset discards any in-flight strobe or response
    always_ff @(posedge clk) begin
        if (rst) begin
            is_write_q    <= 1'b0;
            tmo_cnt_q     <= 4'd0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_data_q    <= 8'h00;
            rsp_err_q     <= 1'b0;
            bus_enable_q  <= 1'b0;
            bus_we_n_q    <= 1'b1;
            bus_addr_q    <= 3'd0;
            bus_dout_q    <= 8'h00;
            irq_prev_q    <= 1'b1;
            irq_pending_q <= 1'b0;
            irq_count_q   <= '0;
        end else begin
            is_write_q    <= is_write_d;
            tmo_cnt_q     <= tmo_cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            bus_enable_q  <= bus_enable_d;
            bus_we_n_q    <= bus_we_n_d;
            bus_addr_q    <= bus_addr_d;
            bus_dout_q    <= bus_dout_d;
            irq_prev_q    <= irq_prev_d;
            irq_pending_q <= irq_pending_d;
            irq_count_q   <= irq_count_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_write   = rsp_write_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.bus_enable  = bus_enable_q;
    assign bus.bus_we_n    = bus_we_n_q;
    assign bus.bus_addr    = bus_addr_q;
    assign bus.bus_dout    = bus_dout_q;
    assign bus.irq_pending = irq_pending_q;
    assign bus.irq_count   = irq_count_q;
endmodule

// File: tb/tb_rriot_bus_master.sv
// Bench for rriot_bus_master: directed and random commands against a timer responder.
// Expected response, latency and irq counts come from a transaction-level model.
// Response backpressure is exercised by holding rsp_ready low with a new command offered.
module tb_rriot_bus_master;
    localparam int RT = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rriot_bus_master_if #(.IRQ_COUNT_W(CW)) ifc ();

    rriot_bus_master #(.READ_TIMEOUT(RT), .IRQ_COUNT_W(CW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Timer responder: answers reads of even addresses with resp_din, resp_dly cycles
    // after the strobe cycle (0 = never); bus_din is noise whenever oe is low.
    logic [7:0] resp_din;
    int         resp_dly;
    int         oe_cnt  = 0;
    int         strb_cnt = 0;
    always @(posedge clk) begin
        #1;
        ifc.bus_oe  = 1'b0;
        ifc.bus_din = 8'($urandom);
        if (oe_cnt > 0) begin
            oe_cnt--;
            if (oe_cnt == 0) begin
                ifc.bus_oe  = 1'b1;
                ifc.bus_din = resp_din;
            end
        end
        if (ifc.bus_enable) begin
            strb_cnt++;
            if (ifc.bus_we_n && !ifc.bus_addr[0]) oe_cnt = resp_dly;
        end
    end

    // One host transaction, checked against the model's response and latency
    task automatic do_txn(input logic wr, input logic [2:0] a, input logic [7:0] wd,
                          input logic [7:0] din, input int dly, input int hold);
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_lat;
        int         n;
        int         s0;
        if (wr) begin
            exp_lat = 2; exp_data = 8'h00; exp_err = 1'b0;
        end else if (!a[0] && dly >= 1 && dly <= RT) begin
            exp_lat = 2 + dly; exp_data = din; exp_err = 1'b0;
        end else begin
            exp_lat = 2 + RT; exp_data = 8'h00; exp_err = 1'b1;
        end
        resp_din = din;
        resp_dly = dly;
        s0 = strb_cnt;
        chk("cmd_ready_idle", ifc.cmd_ready, 1);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_write = wr;
        ifc.cmd_addr  = a;
        ifc.cmd_wdata = wd;
        tick();
        ifc.cmd_valid = 1'b0;
        ifc.cmd_wdata = 8'($urandom);
        chk("strobe_en", ifc.bus_enable, 1);
        chk("strobe_we_n", ifc.bus_we_n, {31'd0, ~wr});
        chk("strobe_addr", ifc.bus_addr, a);
        chk("strobe_dout", ifc.bus_dout, wd);
        chk("cmd_ready_busy", ifc.cmd_ready, 0);
        tick();
        n = 2;
        chk("strobe_end_en", ifc.bus_enable, 0);
        chk("strobe_end_we_n", ifc.bus_we_n, 1);
        chk("addr_hold", ifc.bus_addr, a);
        chk("dout_hold", ifc.bus_dout, wd);
        while (!ifc.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("rsp_latency", n, exp_lat);
        chk("rsp_write", ifc.rsp_write, wr);
        chk("rsp_data", ifc.rsp_data, exp_data);
        chk("rsp_err", ifc.rsp_err, exp_err);
        // offer a new command while the response is pending: it must not be taken
        ifc.cmd_valid = 1'b1;
        ifc.cmd_write = 1'($urandom);
        ifc.cmd_addr  = 3'($urandom);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", ifc.rsp_valid, 1);
            chk("hold_data", ifc.rsp_data, exp_data);
            chk("hold_err", ifc.rsp_err, exp_err);
            chk("hold_cmd_ready", ifc.cmd_ready, 0);
            chk("hold_no_strobe", ifc.bus_enable, 0);
        end
        ifc.rsp_ready = 1'b1;
        tick();
        ifc.rsp_ready = 1'b0;
        ifc.cmd_valid = 1'b0;
        chk("hs_rsp_valid", ifc.rsp_valid, 0);
        chk("hs_cmd_ready", ifc.cmd_ready, 1);
        chk("hs_no_accept", ifc.bus_enable, 0);
        chk("one_strobe", strb_cnt - s0, 1);
    endtask

    // Irq model: a driven high->low transition is one event
    logic        irq_lvl  = 1'b1;
    int          ref_cnt  = 0;
    logic        ref_pend = 1'b0;

    task automatic irq_step(input logic lvl, input logic ack, input logic check);
        logic ev;
        ev = irq_lvl && !lvl;
        ifc.bus_irq = lvl;
        ifc.irq_ack = ack;
        tick();
        ifc.irq_ack = 1'b0;
        if (ev) begin
            ref_pend = 1'b1;
            ref_cnt  = ack ? 1 : ((ref_cnt < 255) ? ref_cnt + 1 : 255);
        end else if (ack) begin
            ref_pend = 1'b0;
            ref_cnt  = 0;
        end
        irq_lvl = lvl;
        if (check) begin
            chk("irq_count", ifc.irq_count, ref_cnt);
            chk("irq_pending", ifc.irq_pending, ref_pend);
        end
    endtask

    initial begin
        logic       wr;
        logic [2:0] a;
        rst           = 1'b1;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_write = 1'b0;
        ifc.cmd_addr  = 3'd0;
        ifc.cmd_wdata = 8'h00;
        ifc.rsp_ready = 1'b0;
        ifc.bus_irq   = 1'b1;
        ifc.irq_ack   = 1'b0;
        resp_din      = 8'h00;
        resp_dly      = 0;
        repeat (2) tick();
        chk("rst_bus_enable", ifc.bus_enable, 0);
        chk("rst_bus_we_n", ifc.bus_we_n, 1);
        chk("rst_bus_addr", ifc.bus_addr, 0);
        chk("rst_bus_dout", ifc.bus_dout, 0);
        chk("rst_cmd_ready", ifc.cmd_ready, 1);
        chk("rst_rsp_valid", ifc.rsp_valid, 0);
        chk("rst_rsp_write", ifc.rsp_write, 0);
        chk("rst_rsp_data", ifc.rsp_data, 0);
        chk("rst_rsp_err", ifc.rsp_err, 0);
        chk("rst_irq_pending", ifc.irq_pending, 0);
        chk("rst_irq_count", ifc.irq_count, 0);
        rst = 1'b0;
        tick();

        // directed: write, fast read, odd-address timeout, long backpressure
        do_txn(1'b1, 3'b111, 8'h10, 8'h00, 0, 0);
        do_txn(1'b0, 3'b100, 8'h00, 8'h0E, 1, 0);
        do_txn(1'b0, 3'b001, 8'h00, 8'h55, 1, 0);
        do_txn(1'b0, 3'b010, 8'h00, 8'hA7, RT, 5);
        do_txn(1'b0, 3'b110, 8'h00, 8'h3C, RT + 1, 1);
        do_txn(1'b1, 3'b011, 8'hFF, 8'h00, 0, 5);

        // random commands
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom);
            a  = 3'($urandom);
            do_txn(wr, a, 8'($urandom), 8'($urandom), $urandom_range(0, 6), $urandom_range(0, 3));
        end

        // irq: three pulses, ack with a coincident fourth, saturation, ack
        for (int i = 0; i < 3; i++) begin
            irq_step(1'b0, 1'b0, 1'b0);
            irq_step(1'b1, 1'b0, 1'b0);
        end
        chk("irq_three", ifc.irq_count, 3);
        chk("irq_three_pend", ifc.irq_pending, 1);
        irq_step(1'b0, 1'b1, 1'b0);
        chk("irq_ack_event_cnt", ifc.irq_count, 1);
        chk("irq_ack_event_pend", ifc.irq_pending, 1);
        irq_step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            irq_step(1'b0, 1'b0, 1'b0);
            irq_step(1'b1, 1'b0, 1'b0);
        end
        chk("irq_saturate", ifc.irq_count, 255);
        irq_step(1'b1, 1'b1, 1'b1);
        chk("irq_ack_clear", ifc.irq_count, 0);
        for (int i = 0; i < 200; i++)
            irq_step(($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0), 1'b1);
        irq_step(1'b1, 1'b0, 1'b1);

        // reset while a read waits for oe
        irq_step(1'b0, 1'b0, 1'b0);
        irq_step(1'b1, 1'b0, 1'b0);
        resp_dly      = 0;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_write = 1'b0;
        ifc.cmd_addr  = 3'b101;
        tick();
        ifc.cmd_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_bus_enable", ifc.bus_enable, 0);
        chk("mid_rst_cmd_ready", ifc.cmd_ready, 1);
        chk("mid_rst_rsp_valid", ifc.rsp_valid, 0);
        chk("mid_rst_irq_count", ifc.irq_count, 0);
        rst      = 1'b0;
        ref_cnt  = 0;
        ref_pend = 1'b0;
        repeat (RT + 3) tick();
        chk("post_rst_no_rsp", ifc.rsp_valid, 0);
        chk("post_rst_cmd_ready", ifc.cmd_ready, 1);
        do_txn(1'b0, 3'b000, 8'h00, 8'h81, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
